// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op encodings, FSM states and the step-counter width helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    function automatic int step_cnt_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// Combinational restoring-division slice: retires STEPS quotient bits per call,
// shifting dividend bits MSB-first out of quo_in and quotient bits into its LSB.
module muldiv_div_step #(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN+1:0] trial;
    logic [XLEN+1:0] diff;

    // A negative trial difference (top bit set) means the divisor did not fit: restore.
    always_comb begin
        rem   = rem_in;
        quo   = quo_in;
        trial = '0;
        diff  = '0;
        for (int i = 0; i < STEPS; i++) begin
            trial = {rem, quo[XLEN-1]};
            diff  = trial - {2'b00, divisor};
            if (!diff[XLEN+1]) begin
                rem = diff[XLEN:0];
                quo = {quo[XLEN-2:0], 1'b1};
            end else begin
                rem = trial[XLEN:0];
                quo = {quo[XLEN-2:0], 1'b0};
            end
        end
        rem_out = rem;
        quo_out = quo;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: magnitude shift-add multiply and
// restoring divide, one-cycle sign fix-up, valid/ready channels and flush support.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_op1,
    input  logic [XLEN-1:0]  req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = step_cnt_width(XLEN);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BITS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN / DIV_BITS - 1);
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt;
    md_op_e            op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN:0]     prem;
    logic              accept;

    md_op_e            req_op_e;
    logic              op1_signed, op2_signed, sign1, sign2;
    logic              req_is_div, req_is_rem, req_neg, div_zero, div_ovf, req_special;
    logic [XLEN-1:0]   mag1, mag2, special_data;

    logic [XLEN+MUL_BITS-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_next;
    logic [XLEN:0]            rem_next;
    logic [XLEN-1:0]          quo_next;
    logic [2*XLEN-1:0]        prod_fix;
    logic [XLEN-1:0]          quo_fix, rem_fix, fix_data;

    // Request decode: operand magnitudes, final result sign and the early-out results.
    always_comb begin
        req_op_e   = md_op_e'(req_op);
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (req_op_e)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            MD_MULHSU: op1_signed = 1'b1;
            default: ;
        endcase
        req_is_div  = req_op[2];
        req_is_rem  = req_op[2] & req_op[1];
        sign1       = op1_signed & req_op1[XLEN-1];
        sign2       = op2_signed & req_op2[XLEN-1];
        mag1        = sign1 ? -req_op1 : req_op1;
        mag2        = sign2 ? -req_op2 : req_op2;
        req_neg     = req_is_rem ? sign1 : (sign1 ^ sign2);
        div_zero    = req_is_div && (req_op2 == '0);
        div_ovf     = req_is_div && op1_signed && (req_op1 == MIN_VAL) && (req_op2 == '1);
        req_special = div_zero | div_ovf;
        if (req_is_rem) begin
            special_data = div_zero ? req_op1 : '0;
        end else begin
            special_data = div_zero ? '1 : MIN_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every other transition, including a DONE handshake.
    always_comb begin
        state_next = state;
        req_ready  = (state == ST_IDLE) && !flush;
        busy       = (state != ST_IDLE);
        resp_valid = (state == ST_DONE);
        accept     = req_valid && req_ready;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_next = req_special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == '0) state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: if (resp_ready) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Radix-2^MUL_BITS step: add multiplicand*digit into the high half, shift right.
    assign mul_sum  = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]}
                    + ({{MUL_BITS{1'b0}}, divisor_q} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]});
    assign mul_next = {mul_sum, acc[XLEN-1:MUL_BITS]};

    muldiv_div_step #(
        .XLEN  (XLEN),
        .STEPS (DIV_BITS)
    ) u_div_step (
        .rem_in  (prem),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_q ? -prem[XLEN-1:0] : prem[XLEN-1:0];
        case (op_q)
            MD_MUL:                       fix_data = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_data = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_data = quo_fix;
            default:                      fix_data = rem_fix;
        endcase
    end

    // Multiply keeps the multiplicand in divisor_q and the multiplier in acc's low half;
    // divide keeps the dividend/quotient in acc's low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= MD_MUL;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            divisor_q <= '0;
            prem      <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else if (accept) begin
            op_q  <= req_op_e;
            tag_q <= req_tag;
            neg_q <= req_neg;
            prem  <= '0;
            if (req_is_div) begin
                divisor_q <= mag2;
                acc       <= {{XLEN{1'b0}}, mag1};
                cnt       <= DIV_LAST;
            end else begin
                divisor_q <= mag1;
                acc       <= {{XLEN{1'b0}}, mag2};
                cnt       <= MUL_LAST;
            end
            if (req_special) begin
                resp_data <= special_data;
                resp_tag  <= req_tag;
            end
        end else if (!flush) begin
            if (state == ST_CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (op_q[2]) begin
                    acc[XLEN-1:0] <= quo_next;
                    prem          <= rem_next;
                end else begin
                    acc <= mul_next;
                end
            end else if (state == ST_FIX) begin
                resp_data <= fix_data;
                resp_tag  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus a randomized sweep
// against an arithmetic reference model, including flush and back-pressure.
module tb_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int MUL_BITS = 4;
    localparam int DIV_BITS = 1;
    localparam int TAG_W    = 5;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [XLEN-1:0]  req_op1 = '0;
    logic [XLEN-1:0]  req_op2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_data;
    logic [4:0]  last_tag;
    int          last_lat;

    muldiv_unit #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS),
        .DIV_BITS (DIV_BITS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = '0;
        case (op)
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            OP_DIV:    begin
                if (b == 0) r = '1;
                else begin p = sa / sb; r = p[31:0]; end
            end
            OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    begin
                if (b == 0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= OP_DIV) begin
            if (b == 0) return 1;
            if ((op == OP_DIV || op == OP_REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
            return XLEN / DIV_BITS + 2;
        end
        return XLEN / MUL_BITS + 2;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. flush_at>0 kills the op in that cycle after accept;
    // hold keeps resp_ready low for that many cycles once the response is up.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, input int hold, input int flush_at);
        logic [31:0] exp;
        int exp_lat, lat, waitc;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        waitc   = 0;
        while (!req_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            checkOutput("req_ready timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        req_tag   = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (flush_at > 0) begin
            repeat (flush_at - 1) @(negedge clk);
            flush = 1'b1;
            #1 checkOutput("flush blocks req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            flush = 1'b0;
            checkOutput("flush kills resp_valid", 64'(resp_valid), 64'd0);
            checkOutput("flush clears busy", 64'(busy), 64'd0);
            return;
        end
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        last_data = resp_data;
        last_tag  = resp_tag;
        last_lat  = lat;
        checkOutput($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
        checkOutput($sformatf("data op%0d %h,%h", op, a, b), 64'(resp_data), 64'(exp));
        checkOutput("tag", 64'(resp_tag), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("hold data", 64'(resp_data), 64'(exp));
            checkOutput("hold tag", 64'(resp_tag), 64'(tag));
            checkOutput("hold req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("resp_valid drops", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset resp_data", 64'(resp_data), 64'd0);
        checkOutput("reset resp_tag", 64'(resp_tag), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("req_ready after reset", 64'(req_ready), 64'd1);

        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0);
        checkOutput("t1 mul data", 64'(last_data), 64'hFFFF_FFEB);
        checkOutput("t1 mul latency", 64'(last_lat), 64'd10);

        applyStimulus(OP_MULH, MIN32, 32'hFFFF_FFFF, 5'd1, 0, 0);
        checkOutput("t2 mulh", 64'(last_data), 64'h0000_0000);
        applyStimulus(OP_MULHSU, MIN32, 32'hFFFF_FFFF, 5'd2, 0, 0);
        checkOutput("t2 mulhsu", 64'(last_data), 64'h8000_0000);
        applyStimulus(OP_MULHU, MIN32, 32'hFFFF_FFFF, 5'd3, 0, 0);
        checkOutput("t2 mulhu", 64'(last_data), 64'h7FFF_FFFF);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0);
        checkOutput("t3 div", 64'(last_data), 64'hFFFF_FFFD);
        checkOutput("t3 div latency", 64'(last_lat), 64'd34);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 0);
        checkOutput("t3 rem", 64'(last_data), 64'hFFFF_FFFF);
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 5'd7, 0, 0);
        checkOutput("t3 divu", 64'(last_data), 64'd3);

        applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd8, 0, 0);
        checkOutput("t4 divu by 0", 64'(last_data), 64'hFFFF_FFFF);
        checkOutput("t4 special latency", 64'(last_lat), 64'd1);
        applyStimulus(OP_REM, 32'd5, 32'd0, 5'd9, 0, 0);
        checkOutput("t4 rem by 0", 64'(last_data), 64'd5);
        applyStimulus(OP_DIV, MIN32, 32'hFFFF_FFFF, 5'd10, 0, 0);
        checkOutput("t4 div ovf", 64'(last_data), 64'h8000_0000);
        applyStimulus(OP_REM, MIN32, 32'hFFFF_FFFF, 5'd11, 0, 0);
        checkOutput("t4 rem ovf", 64'(last_data), 64'd0);

        applyStimulus(OP_DIV, 32'd100, 32'd7, 5'd12, 0, 10);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checkOutput("t5 killed op never responds", 64'(seen), 64'd0);
        applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd13, 0, 0);
        checkOutput("t5 mul after flush", 64'(last_data), 64'd12);
        checkOutput("t5 tag after flush", 64'(last_tag), 64'd13);

        flush = 1'b1;
        req_valid = 1'b1;
        req_op = OP_MUL;
        @(posedge clk);
        #1 req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush+req not accepted", 64'(busy), 64'd0);

        applyStimulus(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, 5, 0);

        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_op1   = 32'd1000;
        req_op2   = 32'd3;
        req_tag   = 5'd22;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("mid reset resp_data", 64'(resp_data), 64'd0);
        checkOutput("mid reset resp_tag", 64'(resp_tag), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("req_ready after mid reset", 64'(req_ready), 64'd1);

        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = rand_operand();
            b   = rand_operand();
            lat = ref_latency(op, a, b);
            applyStimulus(op, a, b, 5'($urandom), $urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
